logic_gate_unit: RTL and testbench

Parametrised, pipelined bitwise logic unit: applies one of eight selectable gate functions (NOT, NAND, NOR, AND, OR, XOR, XNOR, PASS) across WIDTH-bit operands. Results are delivered through a two-stage valid/ready pipeline. It generalises the fixed single-bit NOT/NAND/NOR gate block into a streaming datapath element. It is usable wherever gate operations must be applied per transaction under back-pressure.

---
 rtl/logic_gate_unit.sv | 137 +++++++++++++
 tb/tb_logic_gate_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gate_unit.sv
// logic_gate_unit: applies one of eight bitwise gate functions to WIDTH-bit operands.
// Latency: the result is registered two edges after the input is accepted (S1 operands, then S2 result).
// Backpressure: valid/ready. in_ready = adv1 is combinational from out_ready, so a full pipe still sustains 1/cycle.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   in_valid/in_ready     input handshake carrying op[2:0], a, b
//   out_valid/out_ready   output handshake carrying y and y_red
//   y_red                 {^y, |y, &y}; constant 0 unless LGU_REDUCE_EN is defined
//   done_cnt              completed output transfers, wraps modulo 2^CNT_W
//
// Build option: define LGU_REDUCE_EN to build the registered reduction bits.
module logic_gate_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       y_red,
  output logic [CNT_W-1:0] done_cnt
);

  // Stage 1: captured operands
  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;

  // Stage 2: registered result
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] y_q, y_d;

  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic             adv1, adv2;
  logic [WIDTH-1:0] result;

  always_comb begin
    // A stage may advance when it is empty or its successor is advancing.
    adv2 = !s2_valid_q || out_ready;
    adv1 = !s1_valid_q || adv2;

    result = '0;
    case (s1_op_q)
      3'd0:    result = ~s1_a_q;
      3'd1:    result = ~(s1_a_q & s1_b_q);
      3'd2:    result = ~(s1_a_q | s1_b_q);
      3'd3:    result = s1_a_q & s1_b_q;
      3'd4:    result = s1_a_q | s1_b_q;
      3'd5:    result = s1_a_q ^ s1_b_q;
      3'd6:    result = ~(s1_a_q ^ s1_b_q);
      default: result = s1_b_q;
    endcase

    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (adv1) begin
      // Operands may be garbage when in_valid is low; only the valid bit matters.
      s1_valid_d = in_valid;
      s1_op_d    = op;
      s1_a_d     = a;
      s1_b_d     = b;
    end

    s2_valid_d = s2_valid_q;
    y_d        = y_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      y_d        = result;
    end

    done_cnt_d = done_cnt_q;
    if (s2_valid_q && out_ready) begin
      done_cnt_d = done_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      done_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      done_cnt_q <= done_cnt_d;
    end
  end

`ifdef LGU_REDUCE_EN
  logic [2:0] y_red_q, y_red_d;

  // Reductions are taken from the same result loaded into y, so they share its stall behaviour.
  always_comb begin
    y_red_d = y_red_q;
    if (adv2) begin
      y_red_d = {^result, |result, &result};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_red_q <= 3'b000;
    end else begin
      y_red_q <= y_red_d;
    end
  end

  assign y_red = y_red_q;
`else
  assign y_red = 3'b000;
`endif

  assign in_ready  = adv1;
  assign out_valid = s2_valid_q;
  assign y         = y_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
module tb_logic_gate_unit;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  y;
  logic [2:0]    y_red;
  logic [CW-1:0] done_cnt;

  always #5 clk = ~clk;

  logic_gate_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .y_red     (y_red),
    .done_cnt  (done_cnt)
  );

  typedef struct packed {
    logic [W-1:0] y;
    logic [2:0]   red;
  } exp_t;

  exp_t          sb_q[$];
  int            errors = 0;
  int            checks = 0;
  logic [CW-1:0] exp_cnt = '0;
  int            offers = 0;

  // Per-opcode truth table indexed by {a_bit, b_bit}.
  function automatic logic [3:0] truth(input logic [2:0] o);
    case (o)
      3'd0:    return 4'b0011;
      3'd1:    return 4'b0111;
      3'd2:    return 4'b0001;
      3'd3:    return 4'b1000;
      3'd4:    return 4'b1110;
      3'd5:    return 4'b0110;
      3'd6:    return 4'b1001;
      default: return 4'b1010;
    endcase
  endfunction

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
    exp_t       e;
    logic [3:0] t;
    int         n;
    t = truth(o);
    for (int i = 0; i < W; i++) e.y[i] = t[{aa[i], bb[i]}];
    n = $countones(e.y);
`ifdef LGU_REDUCE_EN
    e.red = {(n % 2) == 1, n > 0, n == W};
`else
    e.red = 3'b000;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive at negedge, decide acceptance just after.
  task automatic offer(input logic v, input logic [2:0] o, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic ordy, output logic acc);
    @(negedge clk);
    in_valid  = v;
    op        = o;
    a         = aa;
    b         = bb;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (v) offers++;
    if (acc) sb_q.push_back(model(o, aa, bb));
  endtask

  task automatic send(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic ordy);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      offer(1'b1, o, aa, bb, ordy, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected acceptance");
    end
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    offer(1'b0, 3'd0, '0, '0, ordy, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 50) begin
      idle(1'b1);
      n++;
    end
    idle(1'b1);
    chk("drain_empty", sb_q.size(), 0);
  endtask

  // Monitor: samples 1ns before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst !== 1'b1) begin
        chk("done_cnt", done_cnt, exp_cnt);
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out: got out_valid=1 y=%0h expected no output", y);
          end else begin
            chk("y", y, sb_q[0].y);
            chk("y_red", y_red, sb_q[0].red);
            if (out_ready) begin
              void'(sb_q.pop_front());
              exp_cnt = exp_cnt + 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    sb_q.delete();
    exp_cnt  = '0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_y_red", y_red, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic       acc;
    int         nacc;
    logic [2:0] ops[4];
    logic [W-1:0] as[4], bs[4];
    exp_t       e1;

    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();

    // Single NAND transaction with latency check.
    send(3'd1, 8'hF0, 8'h3C, 1'b1);
    e1 = model(3'd1, 8'hF0, 8'h3C);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("lat_after_accept", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_valid", out_valid, 1);
    chk("lat_y", y, 8'hCF);
    chk("lat_y_red", y_red, e1.red);
    drain();
    chk("t1_done_cnt", done_cnt, 1);

    // All opcodes back to back: each must be accepted on its first offer.
    offers = 0;
    for (int i = 0; i < 8; i++) send(3'(i), 8'hAA, 8'h0F, 1'b1);
    chk("opcodes_rate", offers, 8);
    drain();

    // Back-pressure: four offered, only two fit.
    for (int i = 0; i < 4; i++) begin
      ops[i] = 3'(3 + i);
      as[i]  = W'($urandom);
      bs[i]  = W'($urandom);
    end
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      if (nacc < 4) begin
        offer(1'b1, ops[nacc], as[nacc], bs[nacc], 1'b0, acc);
        if (acc) nacc++;
      end
    end
    chk("bp_accepts", nacc, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    for (int i = 2; i < 4; i++) send(ops[i], as[i], bs[i], 1'b1);
    drain();

    // Full pipe with simultaneous input and output transfers.
    send(3'd5, W'($urandom), W'($urandom), 1'b0);
    send(3'd6, W'($urandom), W'($urandom), 1'b0);
    for (int i = 0; i < 6; i++) begin
      offer(1'b1, 3'($urandom), W'($urandom), W'($urandom), 1'b1, acc);
      chk("full_in_ready", acc, 1);
      chk("full_out_valid", out_valid, 1);
    end
    drain();

    // Reset with two entries in flight; nothing stale may emerge afterwards.
    send(3'd3, 8'hFF, 8'h81, 1'b0);
    send(3'd4, 8'h12, 8'h34, 1'b0);
    do_reset();
    repeat (4) idle(1'b1);

    // Counter wrap with a 4-bit counter: 17 transfers end at 1.
    for (int i = 0; i < 17; i++) send(3'($urandom), W'($urandom), W'($urandom), 1'b1);
    drain();
    chk("wrap_done_cnt", done_cnt, 1);

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      offer(($urandom_range(0, 9) < 7), 3'($urandom), W'($urandom), W'($urandom),
            ($urandom_range(0, 9) < 6), acc);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
